npc_ras_unit: RTL

NPC_RAS_UNIT -- requirements
Module: npc_ras_unit

---
 rtl/npc_ras_unit_pkg.sv | 19 +
 rtl/ras_stack.sv | 69 ++++++
 rtl/npc_ras_unit.sv | 92 +++++++++
 3 files changed

// File: rtl/npc_ras_unit_pkg.sv
// Shared definitions for the next-PC unit: op encodings and the default reset PC.
package npc_ras_unit_pkg;

  localparam int unsigned NPC_OP_W = 3;
  localparam int unsigned IMM_W    = 26;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic [NPC_OP_W-1:0] {
    NPC_PLUS4  = 3'b000,
    NPC_BRANCH = 3'b001,
    NPC_JUMP   = 3'b010,
    NPC_JR     = 3'b011,
    NPC_CALL   = 3'b100,
    NPC_CALLR  = 3'b101,
    NPC_RET    = 3'b110
  } npc_op_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]  mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic [PTR_W-1:0] top_idx;

  // ptr_q is the next free slot; the top entry sits one below it.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (cnt_q != CNT_W'(RAS_DEPTH)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (pop && (cnt_q != '0)) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == CNT_W'(RAS_DEPTH));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  // Entry storage is never read while empty, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[ptr_q] <= wdata;
    end
  end

  assign top_idx = ptr_q - PTR_W'(1);
  assign top     = mem_q[top_idx];
  assign empty   = empty_q;
  assign full    = full_q;

endmodule

// File: rtl/npc_ras_unit.sv
// Next-PC selection and PC register with return-address-stack prediction for RET.
module npc_ras_unit
  import npc_ras_unit_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     RAS_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                stall_i,
  input  logic [NPC_OP_W-1:0] npc_op_i,
  input  logic [IMM_W-1:0]    imm_i,
  input  logic [XLEN-1:0]     jr_i,
  output logic [XLEN-1:0]     pc_o,
  output logic [XLEN-1:0]     npc_o,
  output logic                ras_empty_o,
  output logic                ras_full_o,
  output logic                ras_mismatch_o
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pcplus4;
  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] j_tgt;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty, ras_full;
  logic            push_req, pop_req;

  assign pcplus4 = pc_q + XLEN'(4);
  assign br_tgt  = pcplus4 + {{(XLEN-18){imm_i[15]}}, imm_i[15:0], 2'b00};
  assign j_tgt   = {pcplus4[XLEN-1:28], imm_i, 2'b00};

  // Target mux; RET on an empty stack falls back to the register target.
  always_comb begin
    npc_o          = pcplus4;
    push_req       = 1'b0;
    pop_req        = 1'b0;
    ras_mismatch_o = 1'b0;
    case (npc_op_i)
      NPC_BRANCH: npc_o = br_tgt;
      NPC_JUMP:   npc_o = j_tgt;
      NPC_JR:     npc_o = jr_i;
      NPC_CALL: begin
        npc_o    = j_tgt;
        push_req = 1'b1;
      end
      NPC_CALLR: begin
        npc_o    = jr_i;
        push_req = 1'b1;
      end
      NPC_RET: begin
        if (ras_empty) begin
          npc_o = jr_i;
        end else begin
          npc_o          = ras_top;
          pop_req        = 1'b1;
          ras_mismatch_o = (ras_top != jr_i);
        end
      end
      default: npc_o = pcplus4;
    endcase
    pc_d = stall_i ? pc_q : npc_o;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push_req && !stall_i),
    .pop   (pop_req && !stall_i),
    .wdata (pcplus4),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full)
  );

  assign pc_o        = pc_q;
  assign ras_empty_o = ras_empty;
  assign ras_full_o  = ras_full;

endmodule
